// File: rtl/raptor_divn_pkg.sv
// Shared types and helpers for the raptor_divn radix-2 restoring divider.
package raptor_div_pkg;

   localparam int MAXW = 128;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_RUN  = 2'd1,
      DIV_FIX  = 2'd2,
      DIV_DONE = 2'd3
   } div_state_t;

   // Callers zero-extend into MAXW and keep the low WIDTH bits; negation stays mod 2^WIDTH.
   function automatic logic [MAXW-1:0] abs_w(input logic neg, input logic [MAXW-1:0] x);
      return neg ? -x : x;
   endfunction

endpackage

// File: rtl/raptor_divn_if.sv
// Start/result handshake bundle between the execute stage and raptor_divn.
interface raptor_divn_if #(parameter int WIDTH = 64);
   logic             ld;
   logic             sgn;
   logic             abort;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] qo;
   logic [WIDTH-1:0] ro;
   logic             dvByZr;

   modport master (
      output ld, sgn, abort, a, b,
      input  busy, done, qo, ro, dvByZr
   );

   modport slave (
      input  ld, sgn, abort, a, b,
      output busy, done, qo, ro, dvByZr
   );
endinterface

// File: rtl/raptor_divn_step.sv
// One restoring-division iteration: trial subtract, keep or restore, emit quotient bit.
module raptor_div_step
   import raptor_div_pkg::*;
#(
   parameter int WIDTH = 64
) (
   input  logic [WIDTH:0]   r,
   input  logic             q_msb,
   input  logic [WIDTH-1:0] bb,
   output logic [WIDTH:0]   r_next,
   output logic             q_bit
);

   logic [WIDTH+1:0] shifted;
   logic [WIDTH+1:0] trial;

   // One extra bit of headroom lets r[WIDTH] feed the subtract; it is always 0 since r < bb.
   always_comb begin
      shifted = {r, q_msb};
      trial   = shifted - {2'b00, bb};
      q_bit   = ~trial[WIDTH+1];
      r_next  = q_bit ? trial[WIDTH:0] : shifted[WIDTH:0];
   end

endmodule

// File: rtl/raptor_divn.sv
// Sequential radix-2 restoring divider with signed/unsigned modes, abort and divide-by-zero fast exit.
module raptor_divn
   import raptor_div_pkg::*;
#(
   parameter int WIDTH = 64
) (
   input logic          clk,
   input logic          rst,
   raptor_divn_if.slave bus
);

   localparam int CNTW = $clog2(WIDTH + 1);

   div_state_t       state;
   div_state_t       state_nxt;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] bb;
   logic [WIDTH:0]   r;
   logic [WIDTH:0]   r_step;
   logic             q_bit;
   logic [CNTW-1:0]  cnt;
   logic             qneg;
   logic             rneg;
   logic             a_neg;
   logic             b_neg;
   logic             b_zero;

   always_comb begin
      a_neg  = bus.sgn & bus.a[WIDTH-1];
      b_neg  = bus.sgn & bus.b[WIDTH-1];
      b_zero = (bus.b == '0);
   end

   raptor_div_step #(.WIDTH(WIDTH)) u_step (
      .r      (r),
      .q_msb  (q[WIDTH-1]),
      .bb     (bb),
      .r_next (r_step),
      .q_bit  (q_bit)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= DIV_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         DIV_IDLE: if (bus.ld) state_nxt = b_zero ? DIV_DONE : DIV_RUN;
         DIV_RUN: begin
            if (bus.abort)             state_nxt = DIV_IDLE;
            else if (cnt == CNTW'(1))  state_nxt = DIV_FIX;
         end
         DIV_FIX:  state_nxt = bus.abort ? DIV_IDLE : DIV_DONE;
         DIV_DONE: state_nxt = DIV_IDLE;
         default:  state_nxt = DIV_IDLE;
      endcase
   end

   always_comb begin
      bus.busy = (state == DIV_RUN) || (state == DIV_FIX);
      bus.done = (state == DIV_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q          <= '0;
         bb         <= '0;
         r          <= '0;
         cnt        <= '0;
         qneg       <= 1'b0;
         rneg       <= 1'b0;
         bus.qo     <= '0;
         bus.ro     <= '0;
         bus.dvByZr <= 1'b0;
      end else begin
         case (state)
            DIV_IDLE: begin
               if (bus.ld) begin
                  q    <= WIDTH'(abs_w(a_neg, MAXW'(bus.a)));
                  bb   <= WIDTH'(abs_w(b_neg, MAXW'(bus.b)));
                  qneg <= a_neg ^ b_neg;
                  rneg <= a_neg;
                  r    <= '0;
                  cnt  <= CNTW'(WIDTH);
                  if (b_zero) begin
                     bus.qo     <= '1;
                     bus.ro     <= bus.a;
                     bus.dvByZr <= 1'b1;
                  end
               end
            end
            DIV_RUN: begin
               r   <= r_step;
               q   <= {q[WIDTH-2:0], q_bit};
               cnt <= cnt - CNTW'(1);
            end
            DIV_FIX: begin
               if (!bus.abort) begin
                  bus.qo     <= WIDTH'(abs_w(qneg, MAXW'(q)));
                  bus.ro     <= WIDTH'(abs_w(rneg, MAXW'(r[WIDTH-1:0])));
                  bus.dvByZr <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_raptor_divn.sv
// Directed bench for raptor_divn at WIDTH 64/16/32 with a result scoreboard and reference model.
module tb_raptor_divn;

   logic         clk = 1'b0;
   logic         rst;
   logic [2:0]   ld;
   logic         sgn;
   logic         abort;
   logic [127:0] a_in;
   logic [127:0] b_in;

   always #5 clk = ~clk;

   raptor_divn_if #(.WIDTH(64)) bus64 ();
   raptor_divn_if #(.WIDTH(16)) bus16 ();
   raptor_divn_if #(.WIDTH(32)) bus32 ();

   assign bus64.ld = ld[0];
   assign bus64.sgn = sgn;
   assign bus64.abort = abort;
   assign bus64.a = a_in[63:0];
   assign bus64.b = b_in[63:0];
   assign bus16.ld = ld[1];
   assign bus16.sgn = sgn;
   assign bus16.abort = abort;
   assign bus16.a = a_in[15:0];
   assign bus16.b = b_in[15:0];
   assign bus32.ld = ld[2];
   assign bus32.sgn = sgn;
   assign bus32.abort = abort;
   assign bus32.a = a_in[31:0];
   assign bus32.b = b_in[31:0];

   raptor_divn #(.WIDTH(64)) dut64 (.clk(clk), .rst(rst), .bus(bus64));
   raptor_divn #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
   raptor_divn #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32));

   logic [127:0] qo_v [3];
   logic [127:0] ro_v [3];
   logic         done_v [3];
   logic         busy_v [3];
   logic         dz_v [3];

   assign qo_v[0] = {64'b0, bus64.qo};
   assign ro_v[0] = {64'b0, bus64.ro};
   assign qo_v[1] = {112'b0, bus16.qo};
   assign ro_v[1] = {112'b0, bus16.ro};
   assign qo_v[2] = {96'b0, bus32.qo};
   assign ro_v[2] = {96'b0, bus32.ro};
   assign done_v[0] = bus64.done;
   assign done_v[1] = bus16.done;
   assign done_v[2] = bus32.done;
   assign busy_v[0] = bus64.busy;
   assign busy_v[1] = bus16.busy;
   assign busy_v[2] = bus32.busy;
   assign dz_v[0] = bus64.dvByZr;
   assign dz_v[1] = bus16.dvByZr;
   assign dz_v[2] = bus32.dvByZr;

   typedef struct {
      logic [127:0] q;
      logic [127:0] r;
      logic         dz;
   } exp_t;

   exp_t sbq[$];
   int   nvec = 0;
   int   nerr = 0;
   int   cur  = 0;
   int   cyc  = 0;
   int   bcnt = 0;
   int   wd [3] = '{64, 16, 32};

   function automatic exp_t model(int w, bit s, logic [127:0] a, logic [127:0] b);
      exp_t         e;
      logic [127:0] m, ua, ub;
      bit           an, bn;
      m = (w == 128) ? '1 : ((128'd1 << w) - 128'd1);
      a = a & m;
      b = b & m;
      if (b == '0) begin
         e.q = m;
         e.r = a;
         e.dz = 1'b1;
         return e;
      end
      an = s & a[w-1];
      bn = s & b[w-1];
      ua = an ? ((-a) & m) : a;
      ub = bn ? ((-b) & m) : b;
      e.q = ua / ub;
      e.r = ua % ub;
      if (an ^ bn) e.q = (-e.q) & m;
      if (an) e.r = (-e.r) & m;
      e.dz = 1'b0;
      return e;
   endfunction

   task automatic check(string tag, logic [127:0] obs, logic [127:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      if (busy_v[cur]) bcnt++;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic launch(int i, bit s, logic [127:0] a, logic [127:0] b, bit push);
      if (push) sbq.push_back(model(wd[i], s, a, b));
      @(negedge clk);
      sgn = s;
      a_in = a;
      b_in = b;
      ld[i] = 1'b1;
      @(posedge clk);
      #1;
      ld[i] = 1'b0;
      cur = i;
      cyc = 1;
      bcnt = 0;
   endtask

   task automatic pulse_ld(int i, logic [127:0] a, logic [127:0] b);
      if (busy_v[cur]) bcnt++;
      @(negedge clk);
      a_in = a;
      b_in = b;
      ld[i] = 1'b1;
      @(posedge clk);
      #1;
      ld[i] = 1'b0;
      cyc++;
   endtask

   task automatic wait_done(string tag, int lat, int busy_exp);
      exp_t e;
      bit   seen = 1'b0;
      while (cyc < 400) begin
         if (done_v[cur]) begin
            seen = 1'b1;
            break;
         end
         step();
      end
      check($sformatf("%s latency", tag), 128'(seen ? cyc : 0), 128'(lat));
      check($sformatf("%s busy_cycles", tag), 128'(bcnt), 128'(busy_exp));
      if (seen) begin
         if (sbq.size() == 0) begin
            nvec++;
            nerr++;
            $error("FAIL %s scoreboard: observed done expected no pending result", tag);
         end else begin
            e = sbq.pop_front();
            check($sformatf("%s qo", tag), qo_v[cur], e.q);
            check($sformatf("%s ro", tag), ro_v[cur], e.r);
            check($sformatf("%s dvByZr", tag), 128'(dz_v[cur]), 128'(e.dz));
         end
         check($sformatf("%s busy_in_done", tag), 128'(busy_v[cur]), 128'(0));
         step();
         check($sformatf("%s done_one_cycle", tag), 128'(done_v[cur]), 128'(0));
      end else if (sbq.size() > 0) begin
         void'(sbq.pop_front());
      end
   endtask

   task automatic count_dones(string tag, int n);
      int nd = 0;
      for (int k = 0; k < n; k++) begin
         if (done_v[cur]) nd++;
         step();
      end
      check(tag, 128'(nd), 128'(0));
   endtask

   initial begin
      exp_t ea;
      rst = 1'b1;
      ld = '0;
      sgn = 1'b0;
      abort = 1'b0;
      a_in = '0;
      b_in = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      for (int i = 0; i < 3; i++) begin
         check($sformatf("reset%0d qo", wd[i]), qo_v[i], 128'd0);
         check($sformatf("reset%0d ro", wd[i]), ro_v[i], 128'd0);
         check($sformatf("reset%0d dvByZr", wd[i]), 128'(dz_v[i]), 128'd0);
         check($sformatf("reset%0d busy", wd[i]), 128'(busy_v[i]), 128'd0);
         check($sformatf("reset%0d done", wd[i]), 128'(done_v[i]), 128'd0);
      end

      launch(0, 1'b0, 128'd10005, 128'd27, 1'b1);
      wait_done("u64", 66, 65);
      launch(0, 1'b1, -128'd10005, 128'd27, 1'b1);
      wait_done("s64_na", 66, 65);
      launch(0, 1'b1, 128'd10005, -128'd27, 1'b1);
      wait_done("s64_nb", 66, 65);
      launch(0, 1'b1, -128'd10005, -128'd27, 1'b1);
      wait_done("s64_nn", 66, 65);

      launch(1, 1'b1, 128'h8000, 128'hFFFF, 1'b1);
      wait_done("ovf16", 18, 17);

      launch(0, 1'b0, 128'd123, 128'd0, 1'b1);
      wait_done("dz64", 1, 0);
      launch(0, 1'b1, -128'd5, 128'd0, 1'b1);
      wait_done("dz64s", 1, 0);

      // Second ld mid-operation must neither restart nor queue.
      launch(2, 1'b0, 128'd1000000, 128'd7, 1'b1);
      while (cyc < 4) step();
      pulse_ld(2, 128'd55, 128'd3);
      wait_done("reld32", 34, 33);
      count_dones("reld32 extra_done", 40);

      ea = model(32, 1'b0, 128'd1000000, 128'd7);
      launch(2, 1'b0, 128'd500, 128'd9, 1'b0);
      while (cyc < 10) step();
      @(negedge clk);
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      check("abort32 busy", 128'(busy_v[2]), 128'd0);
      check("abort32 done", 128'(done_v[2]), 128'd0);
      check("abort32 qo_held", qo_v[2], ea.q);
      check("abort32 ro_held", ro_v[2], ea.r);
      check("abort32 dvByZr_held", 128'(dz_v[2]), 128'(ea.dz));
      launch(2, 1'b0, 128'd777777, 128'd13, 1'b1);
      wait_done("post_abort32", 34, 33);

      abort = 1'b1;
      launch(1, 1'b1, -128'd300, 128'd7, 1'b1);
      abort = 1'b0;
      wait_done("abort_ld16", 18, 17);

      launch(0, 1'b0, 128'h0123456789ABCDEF, 128'd3, 1'b0);
      while (cyc < 20) step();
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("midrst busy", 128'(busy_v[0]), 128'd0);
      check("midrst done", 128'(done_v[0]), 128'd0);
      check("midrst qo", qo_v[0], 128'd0);
      check("midrst ro", ro_v[0], 128'd0);
      check("midrst dvByZr", 128'(dz_v[0]), 128'd0);
      count_dones("midrst stray_done", 70);
      launch(0, 1'b0, 128'd100, 128'd7, 1'b1);
      wait_done("post_rst64", 66, 65);

      check("scoreboard drained", 128'(sbq.size()), 128'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/raptor_divn.md
Name: raptor_divn

Overview:
- Parametrised sequential restoring divider, radix-2, one quotient bit per clock.
- Successor to the fixed 64-bit Raptor64 divider. Adds:
  - generic operand width;
  - an explicit busy/accept handshake;
  - an abort input;
  - C-style truncating signed semantics, with the remainder taking the sign of the dividend;
  - a defined divide-by-zero result with a fast exit.
- Sits in the execute stage beside the multiplier; the pipeline stalls on busy.

Parameters:
- WIDTH, 64: operand, quotient and remainder width in bits; any value 8..128.
- CNTW, $clog2(WIDTH+1): iteration counter width; derived, never overridden.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- ld  in  1  start request; accepted only while busy=0.
- sgn  in  1  1 = signed (two's complement) divide, 0 = unsigned; sampled when ld is accepted.
- abort  in  1  cancel in-flight operation; no result produced.
- a  in  WIDTH  dividend; sampled when ld is accepted.
- b  in  WIDTH  divisor; sampled when ld is accepted.
- busy  out  1  high from the cycle after acceptance until done is high.
- done  out  1  one-cycle pulse; qo/ro/dvByZr valid in that cycle.
- qo  out  WIDTH  quotient; held until the next done.
- ro  out  WIDTH  remainder; held until the next done.
- dvByZr  out  1  divisor was zero; valid with done, held with qo/ro.

Behaviour:
- Reset values: qo=0, ro=0, dvByZr=0, done=0, busy=0, state=IDLE, counter=0.
- Reset wins over every other input in the same cycle. Reset mid-operation returns to IDLE with no done pulse.
- States: IDLE, DIV, FIX, DONE.
- IDLE
  - ld=1 accepts the operands.
  - Latch |a| into the q shift register and |b| into bb. Magnitudes apply only when sgn=1; otherwise use the raw values.
  - Latch qneg = sgn & (a[MSB]^b[MSB]) and rneg = sgn & a[MSB].
  - Clear the partial remainder r (WIDTH+1 bits) and load counter=WIDTH.
  - If b==0 go to DONE; otherwise go to DIV.
- DIV, each cycle:
  - trial = {r[WIDTH-1:0], q[MSB]} - {1'b0, bb}.
  - If trial is non-negative: r<=trial, shift 1 into q. Otherwise: r<={r[WIDTH-1:0], q[MSB]}, shift 0 into q.
  - Decrement counter. Leave for FIX in the cycle the counter reaches 0 (exactly WIDTH DIV cycles).
- FIX
  - qo <= qneg ? -q : q; ro <= rneg ? -r[WIDTH-1:0] : r[WIDTH-1:0]; dvByZr <= 0.
  - Go to DONE.
- Divide by zero, written on the IDLE->DONE transition:
  - qo = all ones, ro = a (unmodified raw dividend), dvByZr = 1.
- DONE: done=1, busy=0, return to IDLE.
  - ld in this cycle is ignored; a new ld is accepted the next cycle.
- Latency, counted from the ld-accept edge:
  - normal: done high WIDTH+2 cycles later;
  - divide by zero: done high 1 cycle later.
- busy=1 in DIV and FIX; busy=0 in IDLE and DONE.
- ld while busy is ignored and does not queue.
- abort
  - In DIV or FIX: go to IDLE next cycle; qo/ro/dvByZr unchanged; no done.
  - In IDLE: ignored. If abort and ld arrive together in IDLE, ld is accepted.
  - In DONE: ignored; the pulse completes.
- Signed overflow, most-negative / -1: the natural datapath result, qo = most-negative value, ro = 0, dvByZr = 0. No special case.
- Negation is two's complement modulo 2^WIDTH.
- No $display in synthesizable code.

Decomposition:
- Package raptor_div_pkg:
  - state encoding constants DIV_IDLE, DIV_RUN, DIV_FIX, DIV_DONE (2-bit);
  - function abs_w (conditional two's-complement negate).
- One combinational sub-module, raptor_div_step:
  - inputs: r, q MSB, bb;
  - outputs: next r and quotient bit.
  - A later radix-4 version instantiates it twice per cycle.

Test Plan:
- WIDTH=64, sgn=0, a=10005, b=27 -> done exactly 66 cycles after accept; qo=370, ro=15, dvByZr=0; busy high 65 cycles.
- WIDTH=64, sgn=1:
  - a=-10005, b=27 -> qo=-370, ro=-15;
  - a=10005, b=-27 -> qo=-370, ro=15;
  - a=-10005, b=-27 -> qo=370, ro=-15.
- WIDTH=16, sgn=1, a=16'h8000, b=16'hFFFF -> qo=16'h8000, ro=0, dvByZr=0, done 18 cycles after accept.
- WIDTH=64, b=0, a=123 -> done 1 cycle after accept; qo=all ones, ro=123, dvByZr=1. Repeat with sgn=1, a=-5 -> ro=-5.
- WIDTH=32:
  - ld pulsed again at cycle 5 of an operation -> ignored, single done.
  - abort at cycle 10 -> no done, qo/ro keep their prior values, busy low next cycle.
  - ld accepted the following cycle completes normally.
- Assert rst at cycle 20 of a 64-bit divide -> next cycle all outputs 0, state IDLE, no done pulse; a subsequent 100/7 yields qo=14, ro=2.
